// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes, ALU ops,
// control_type codes, FSM state codes and the decoded control bundle.
`default_nettype none

package mips_mc_control_pkg;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] OP0_JR    = 6'h08;
  localparam logic [5:0] OP0_ADD   = 6'h20;
  localparam logic [5:0] OP0_ADDU  = 6'h21;
  localparam logic [5:0] OP0_SUB   = 6'h22;
  localparam logic [5:0] OP0_AND   = 6'h24;
  localparam logic [5:0] OP0_OR    = 6'h25;
  localparam logic [5:0] OP0_XOR   = 6'h26;
  localparam logic [5:0] OP0_NOR   = 6'h27;
  localparam logic [5:0] OP0_SLT   = 6'h2a;
  localparam logic [5:0] OP0_ADDM  = 6'h2c;

  localparam logic [2:0] ALU_NOP   = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;
  localparam logic [2:0] ALU_NOR   = 3'd6;
  localparam logic [2:0] ALU_XOR   = 3'd7;

  localparam logic [1:0] SRC2_REG  = 2'd0;
  localparam logic [1:0] SRC2_SEXT = 2'd1;
  localparam logic [1:0] SRC2_ZEXT = 2'd2;

  localparam logic [1:0] CT_PC4    = 2'd0;
  localparam logic [1:0] CT_BRANCH = 2'd1;
  localparam logic [1:0] CT_JUMP   = 2'd2;
  localparam logic [1:0] CT_JR     = 2'd3;

  typedef enum logic [2:0] {
    MC_IDLE = 3'd0,
    MC_EXEC = 3'd1,
    MC_MEM  = 3'd2,
    MC_WB   = 3'd3,
    MC_EXC  = 3'd4
  } mc_state_t;

  // rd_src=1 selects rt as destination (I-type), 0 selects rd.
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src2;
    logic       rd_src;
    logic       byte_load;
    logic       slt;
    logic       lui;
    logic       addm;
    logic       mem_read;
    logic       word_we;
    logic       byte_we;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jr;
    logic       jal;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_OTHER0: begin
        case (fn)
          OP0_JR, OP0_ADD, OP0_ADDU, OP0_SUB, OP0_AND, OP0_OR,
          OP0_XOR, OP0_NOR, OP0_SLT, OP0_ADDM: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_LBU, OP_SB, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mc_control_decode.sv
// Combinational instruction decoder: maps opcode/funct to the raw control bundle.
`default_nettype none

module mips_mc_control_decode
  import mips_mc_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_OTHER0: begin
        case (funct)
          OP0_ADD, OP0_ADDU: ctrl.alu_op = ALU_ADD;
          OP0_SUB:           ctrl.alu_op = ALU_SUB;
          OP0_AND:           ctrl.alu_op = ALU_AND;
          OP0_OR:            ctrl.alu_op = ALU_OR;
          OP0_XOR:           ctrl.alu_op = ALU_XOR;
          OP0_NOR:           ctrl.alu_op = ALU_NOR;
          OP0_SLT: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.slt    = 1'b1;
          end
          OP0_JR: begin
            ctrl.jump = 1'b1;
            ctrl.jr   = 1'b1;
          end
          OP0_ADDM: begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.mem_read = 1'b1;
            ctrl.addm     = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: ctrl.jal  = 1'b1;
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.alu_src2 = SRC2_SEXT;
        ctrl.rd_src   = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alu_op   = ALU_SUB;
        ctrl.alu_src2 = SRC2_SEXT;
        ctrl.rd_src   = 1'b1;
        ctrl.slt      = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_op   = (opcode == OP_ANDI) ? ALU_AND :
                        (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        ctrl.alu_src2 = SRC2_ZEXT;
        ctrl.rd_src   = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_src2 = SRC2_ZEXT;
        ctrl.rd_src   = 1'b1;
        ctrl.lui      = 1'b1;
      end
      OP_LW, OP_LBU: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src2  = SRC2_SEXT;
        ctrl.rd_src    = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.byte_load = (opcode == OP_LBU);
      end
      OP_SW, OP_SB: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.alu_src2 = SRC2_SEXT;
        ctrl.word_we  = (opcode == OP_SW);
        ctrl.byte_we  = (opcode == OP_SB);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: IR latch, IDLE/EXEC/MEM/WB/EXC sequencing,
// memory wait timeout and per-state gating of the decoded control bundle.
`default_nettype none

module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src2,
  output logic       rd_src,
  output logic       writeenable,
  output logic       mem_read,
  output logic       word_we,
  output logic       byte_we,
  output logic       byte_load,
  output logic       slt,
  output logic       lui,
  output logic       addm,
  output logic [1:0] control_type,
  output logic       pc_we,
  output logic       done,
  output logic       except,
  output logic [2:0] state
);

  mc_state_t        cur_state;
  mc_state_t        nxt_state;
  logic [5:0]       ir_op;
  logic [5:0]       ir_fn;
  logic [TMO_W-1:0] wait_cnt;
  ctrl_t            ctrl;
  logic             is_store;
  logic             mem_timeout;

  mips_mc_control_decode u_decode (
    .opcode (ir_op),
    .funct  (ir_fn),
    .ctrl   (ctrl)
  );

  assign is_store    = ctrl.word_we | ctrl.byte_we;
  assign mem_timeout = (wait_cnt == TMO_W'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign pc_we       = done;
  assign state       = cur_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= MC_IDLE;
      ir_op     <= '0;
      ir_fn     <= '0;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == MC_IDLE && instr_valid) begin
        ir_op <= opcode;
        ir_fn <= funct;
      end
      // Counter is held at zero outside MEM so every MEM visit starts fresh.
      if (cur_state != MC_MEM) begin
        wait_cnt <= '0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + TMO_W'(1);
      end
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    instr_ready  = 1'b0;
    alu_op       = ALU_NOP;
    alu_src2     = SRC2_REG;
    rd_src       = 1'b0;
    writeenable  = 1'b0;
    mem_read     = 1'b0;
    word_we      = 1'b0;
    byte_we      = 1'b0;
    byte_load    = 1'b0;
    slt          = 1'b0;
    lui          = 1'b0;
    addm         = 1'b0;
    control_type = CT_PC4;
    done         = 1'b0;
    except       = 1'b0;
    unique case (cur_state)
      MC_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          nxt_state = is_legal(opcode, funct) ? MC_EXEC : MC_EXC;
        end
      end
      MC_EXEC: begin
        alu_op   = ctrl.alu_op;
        alu_src2 = ctrl.alu_src2;
        slt      = ctrl.slt;
        lui      = ctrl.lui;
        if (ctrl.branch) begin
          done         = 1'b1;
          control_type = (zero ^ ctrl.branch_ne) ? CT_BRANCH : CT_PC4;
          nxt_state    = MC_IDLE;
        end else if (ctrl.jump) begin
          done         = 1'b1;
          control_type = ctrl.jr ? CT_JR : CT_JUMP;
          nxt_state    = MC_IDLE;
        end else if (ctrl.mem_read || is_store) begin
          nxt_state = MC_MEM;
        end else begin
          nxt_state = MC_WB;
        end
      end
      MC_MEM: begin
        mem_read = ctrl.mem_read;
        word_we  = ctrl.word_we;
        byte_we  = ctrl.byte_we;
        // mem_ready takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          if (is_store) begin
            done      = 1'b1;
            nxt_state = MC_IDLE;
          end else begin
            nxt_state = MC_WB;
          end
        end else if (mem_timeout) begin
          nxt_state = MC_EXC;
        end
      end
      MC_WB: begin
        writeenable  = 1'b1;
        rd_src       = ctrl.rd_src;
        byte_load    = ctrl.byte_load;
        addm         = ctrl.addm;
        done         = 1'b1;
        control_type = ctrl.jal ? CT_JUMP : CT_PC4;
        nxt_state    = MC_IDLE;
      end
      MC_EXC: begin
        except    = 1'b1;
        nxt_state = MC_IDLE;
      end
      default: nxt_state = MC_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control against a per-instruction timeline model.
`default_nettype none

module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset, instr_valid, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       instr_ready, rd_src, writeenable, mem_read, word_we, byte_we;
  logic       byte_load, slt, lui, addm, pc_we, done, except;
  logic [2:0] alu_op, state;
  logic [1:0] alu_src2, control_type;

  int errors = 0;
  int checks = 0;

  mips_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(8)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src2(alu_src2), .rd_src(rd_src), .writeenable(writeenable),
    .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we), .byte_load(byte_load),
    .slt(slt), .lui(lui), .addm(addm), .control_type(control_type), .pc_we(pc_we),
    .done(done), .except(except), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       ready;
    logic [2:0] alu;
    logic [1:0] src2;
    logic       rd_src, we, mr, ww, bw, bl, slt, lui, addm;
    logic [1:0] ct;
    logic       pc_we, done, exc;
    logic [2:0] st;
  } vec_t;

  typedef enum int {K_ILL, K_ALU, K_LOAD, K_ADDM, K_SW, K_SB, K_BEQ, K_BNE, K_J, K_JR, K_JAL} kind_e;

  typedef struct {
    kind_e      kind;
    logic [2:0] alu;
    logic [1:0] src2;
    logic       rd_src, bl, slt, lui;
  } info_t;

  localparam logic [5:0] OPS [16] = '{OP_OTHER0, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
    OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_LBU, OP_SB, OP_SW};
  localparam logic [5:0] FNS [10] = '{OP0_JR, OP0_ADD, OP0_ADDU, OP0_SUB, OP0_AND, OP0_OR,
    OP0_XOR, OP0_NOR, OP0_SLT, OP0_ADDM};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {9'd0, instr_ready, alu_op, alu_src2, rd_src, writeenable, mem_read, word_we,
            byte_we, byte_load, slt, lui, addm, control_type, pc_we, done, except, state};
  endfunction

  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  // Architectural meaning of each instruction: its class and EXEC/WB control values.
  function automatic info_t ref_info(input logic [5:0] op, input logic [5:0] fn);
    info_t r;
    r.kind = K_ILL; r.alu = ALU_NOP; r.src2 = SRC2_REG;
    r.rd_src = 1'b0; r.bl = 1'b0; r.slt = 1'b0; r.lui = 1'b0;
    case (op)
      OP_OTHER0: case (fn)
        OP0_ADD, OP0_ADDU: begin r.kind = K_ALU; r.alu = ALU_ADD; end
        OP0_SUB:  begin r.kind = K_ALU; r.alu = ALU_SUB; end
        OP0_AND:  begin r.kind = K_ALU; r.alu = ALU_AND; end
        OP0_OR:   begin r.kind = K_ALU; r.alu = ALU_OR;  end
        OP0_XOR:  begin r.kind = K_ALU; r.alu = ALU_XOR; end
        OP0_NOR:  begin r.kind = K_ALU; r.alu = ALU_NOR; end
        OP0_SLT:  begin r.kind = K_ALU; r.alu = ALU_SUB; r.slt = 1'b1; end
        OP0_JR:   r.kind = K_JR;
        OP0_ADDM: begin r.kind = K_ADDM; r.alu = ALU_ADD; end
        default:  r.kind = K_ILL;
      endcase
      OP_J:   r.kind = K_J;
      OP_JAL: r.kind = K_JAL;
      OP_BEQ: begin r.kind = K_BEQ; r.alu = ALU_SUB; end
      OP_BNE: begin r.kind = K_BNE; r.alu = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin r.kind = K_ALU; r.alu = ALU_ADD; r.src2 = SRC2_SEXT; r.rd_src = 1'b1; end
      OP_SLTI: begin r.kind = K_ALU; r.alu = ALU_SUB; r.src2 = SRC2_SEXT; r.rd_src = 1'b1; r.slt = 1'b1; end
      OP_ANDI: begin r.kind = K_ALU; r.alu = ALU_AND; r.src2 = SRC2_ZEXT; r.rd_src = 1'b1; end
      OP_ORI:  begin r.kind = K_ALU; r.alu = ALU_OR;  r.src2 = SRC2_ZEXT; r.rd_src = 1'b1; end
      OP_XORI: begin r.kind = K_ALU; r.alu = ALU_XOR; r.src2 = SRC2_ZEXT; r.rd_src = 1'b1; end
      OP_LUI:  begin r.kind = K_ALU; r.src2 = SRC2_ZEXT; r.rd_src = 1'b1; r.lui = 1'b1; end
      OP_LW:   begin r.kind = K_LOAD; r.alu = ALU_ADD; r.src2 = SRC2_SEXT; r.rd_src = 1'b1; end
      OP_LBU:  begin r.kind = K_LOAD; r.alu = ALU_ADD; r.src2 = SRC2_SEXT; r.rd_src = 1'b1; r.bl = 1'b1; end
      OP_SW:   begin r.kind = K_SW; r.alu = ALU_ADD; r.src2 = SRC2_SEXT; end
      OP_SB:   begin r.kind = K_SB; r.alu = ALU_ADD; r.src2 = SRC2_SEXT; end
      default: r.kind = K_ILL;
    endcase
    return r;
  endfunction

  task automatic scramble();
    instr_valid = 1'($urandom);
    opcode      = 6'($urandom);
    funct       = 6'($urandom);
  endtask

  // Drives one instruction. w = MEM cycles without mem_ready before it rises
  // (w >= MEM_TIMEOUT means never); rst_at = MEM cycle in which reset is raised (-1 none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int w, input int rst_at);
    info_t inf;
    vec_t  e;
    int    lat;
    logic  is_mem, is_store;
    inf      = ref_info(op, fn);
    is_store = (inf.kind == K_SW) || (inf.kind == K_SB);
    is_mem   = is_store || (inf.kind == K_LOAD) || (inf.kind == K_ADDM);

    @(negedge clock);
    instr_valid = 1'b1; opcode = op; funct = fn;
    zero = 1'($urandom); mem_ready = 1'($urandom);
    #1 check("accept", obs_vec(), {9'd0, idle_vec()});
    lat = 0;

    @(negedge clock);
    scramble(); zero = z; mem_ready = 1'($urandom); lat++;
    e = '0;
    if (inf.kind == K_ILL) begin
      e.exc = 1'b1; e.st = MC_EXC;
      #1 check("illegal", obs_vec(), {9'd0, e});
      return;
    end
    e.st = MC_EXEC; e.alu = inf.alu; e.src2 = inf.src2; e.slt = inf.slt; e.lui = inf.lui;
    case (inf.kind)
      K_BEQ: begin e.done = 1'b1; e.ct = z ? CT_BRANCH : CT_PC4; end
      K_BNE: begin e.done = 1'b1; e.ct = z ? CT_PC4 : CT_BRANCH; end
      K_J:   begin e.done = 1'b1; e.ct = CT_JUMP; end
      K_JR:  begin e.done = 1'b1; e.ct = CT_JR; end
      default: e.done = 1'b0;
    endcase
    e.pc_we = e.done;
    #1 check("exec", obs_vec(), {9'd0, e});
    if (e.done) begin
      check("latency", 32'(lat), 32'd1);
      return;
    end

    if (is_mem) begin
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        @(negedge clock);
        scramble(); zero = 1'($urandom); lat++;
        mem_ready = (k == w);
        reset     = (k == rst_at);
        e = '0; e.st = MC_MEM;
        e.mr = (inf.kind == K_LOAD) || (inf.kind == K_ADDM);
        e.ww = (inf.kind == K_SW);
        e.bw = (inf.kind == K_SB);
        if (mem_ready && is_store) begin e.done = 1'b1; e.pc_we = 1'b1; end
        #1 check("mem", obs_vec(), {9'd0, e});
        if (k == rst_at) begin
          @(negedge clock);
          reset = 1'b0; instr_valid = 1'b0;
          #1 check("post_reset", obs_vec(), {9'd0, idle_vec()});
          return;
        end
        if (mem_ready) begin
          if (is_store) begin
            check("latency", 32'(lat), 32'(2 + w));
            return;
          end
          break;
        end
        if (k == MEM_TIMEOUT - 1) begin
          @(negedge clock);
          scramble(); mem_ready = 1'b0;
          e = '0; e.exc = 1'b1; e.st = MC_EXC;
          #1 check("timeout", obs_vec(), {9'd0, e});
          return;
        end
      end
    end

    @(negedge clock);
    scramble(); mem_ready = 1'($urandom); lat++;
    e = '0; e.st = MC_WB; e.we = 1'b1; e.rd_src = inf.rd_src; e.bl = inf.bl;
    e.addm = (inf.kind == K_ADDM); e.done = 1'b1; e.pc_we = 1'b1;
    e.ct = (inf.kind == K_JAL) ? CT_JUMP : CT_PC4;
    #1 check("wb", obs_vec(), {9'd0, e});
    check("latency", 32'(lat), is_mem ? 32'(3 + w) : 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int         w;
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1 check("reset", obs_vec(), {9'd0, idle_vec()});
    reset = 1'b0;

    run_instr(OP_OTHER0, OP0_ADD, 1'b0, 0, -1);
    run_instr(OP_BEQ, 6'h00, 1'b1, 0, -1);
    run_instr(OP_BEQ, 6'h00, 1'b0, 0, -1);
    run_instr(OP_SW, 6'h00, 1'b0, 3, -1);
    run_instr(OP_LBU, 6'h00, 1'b0, 99, -1);
    run_instr(6'h3f, 6'h00, 1'b0, 0, -1);
    run_instr(OP_SB, 6'h00, 1'b0, 99, 2);
    run_instr(OP_OTHER0, OP0_ADDM, 1'b0, 1, -1);
    run_instr(OP_LW, 6'h00, 1'b0, MEM_TIMEOUT - 1, -1);
    run_instr(OP_JAL, 6'h00, 1'b0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 9)];
      w  = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
      run_instr(op, fn, 1'($urandom), w, -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        instr_valid = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
        #1 check("idle", obs_vec(), {9'd0, idle_vec()});
      end
    end

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
